pcie_ltssm_ctrl: RTL and testbench

//  Parametrised multi-lane PCIe LTSSM: Detect -> Polling -> Configuration -> L0, plus Recovery/Disabled/Loopback.

---
 rtl/pcie_ltssm_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pcie_ltssm_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pcie_ltssm_ctrl.sv
// Multi-lane PCIe LTSSM: Detect -> Polling -> Configuration -> L0, plus Recovery/Disabled/Loopback.
// Latency: all outputs registered; state and outputs update one cycle after the transition condition.
// Backpressure: tx_ready_i only slows tx_cnt; valid may drop on state exit with no set owed.
module pcie_ltssm_ctrl #(
    parameter int NUM_LANES      = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DETECT_CYCLES  = 8,
    parameter int TS_TX_MIN      = 16,
    parameter int TS_RX_REQ      = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_LANES-1:0] rx_detected_i,
    input  logic [NUM_LANES-1:0] rx_ts1_i,
    input  logic [NUM_LANES-1:0] rx_ts2_i,
    input  logic [NUM_LANES-1:0] rx_idl_i,
    input  logic [NUM_LANES-1:0] rx_eios_i,
    input  logic                 retrain_i,
    input  logic                 link_disable_i,
    input  logic                 loopback_req_i,
    output logic                 tx_valid_o,
    output logic [1:0]           tx_type_o,
    input  logic                 tx_ready_i,
    output logic                 detect_en_o,
    output logic [NUM_LANES-1:0] active_lanes_o,
    output logic                 link_up_o,
    output logic                 timeout_o,
    output logic [3:0]           ltssm_state_o
);

    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TXW = $clog2(TS_TX_MIN + 1);
    localparam int RXW = $clog2(TS_RX_REQ + 1);

    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]  TMR_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  DET_LAST = TW'(DETECT_CYCLES - 1);
    localparam logic [TXW-1:0] TX_MIN   = TXW'(TS_TX_MIN);
    localparam logic [RXW-1:0] RX_REQ   = RXW'(TS_RX_REQ);

    localparam logic [1:0] TX_NONE = 2'd0;
    localparam logic [1:0] TX_TS1  = 2'd1;
    localparam logic [1:0] TX_TS2  = 2'd2;
    localparam logic [1:0] TX_IDL  = 2'd3;

    typedef enum logic [3:0] {
        DETECT_QUIET  = 4'd0,
        DETECT_ACTIVE = 4'd1,
        POLL_ACTIVE   = 4'd2,
        POLL_CONFIG   = 4'd3,
        CONFIG        = 4'd4,
        CONFIG_IDLE   = 4'd5,
        L0            = 4'd6,
        RECOVERY      = 4'd7,
        DISABLED      = 4'd8,
        LOOPBACK      = 4'd9
    } state_e;

    state_e                          state_q, state_d;
    logic [TW-1:0]                   timer_q;
    logic [TXW-1:0]                  tx_cnt_q;
    logic [NUM_LANES-1:0][RXW-1:0]   rx_cnt_q;
    logic [NUM_LANES-1:0]            active_lanes_q;
    logic                            tx_valid_q, detect_en_q, link_up_q, timeout_q;
    logic [1:0]                      tx_type_q;

    logic [NUM_LANES-1:0]            rx_hit;
    logic                            done, timed, timeout_d, latch_d;

    // Next-state decision: expected rx pulse per state, done, timeout (done wins a tie).
    always_comb begin
        rx_hit    = '0;
        done      = (tx_cnt_q == TX_MIN);
        timed     = 1'b0;
        timeout_d = 1'b0;
        latch_d   = 1'b0;
        state_d   = state_q;

        case (state_q)
            POLL_ACTIVE, RECOVERY:  rx_hit = (rx_ts1_i | rx_ts2_i) & active_lanes_q;
            POLL_CONFIG, CONFIG:    rx_hit = rx_ts2_i & active_lanes_q;
            CONFIG_IDLE:            rx_hit = rx_idl_i & active_lanes_q;
            default:                rx_hit = '0;
        endcase

        for (int l = 0; l < NUM_LANES; l++) begin
            if (active_lanes_q[l] && (rx_cnt_q[l] != RX_REQ)) begin
                done = 1'b0;
            end
        end

        case (state_q)
            DETECT_QUIET: begin
                if (timer_q == DET_LAST) state_d = DETECT_ACTIVE;
            end
            DETECT_ACTIVE: begin
                if (timer_q == DET_LAST) begin
                    latch_d = 1'b1;
                    state_d = (|rx_detected_i) ? POLL_ACTIVE : DETECT_QUIET;
                end
            end
            POLL_ACTIVE: begin
                timed = 1'b1;
                if (done) state_d = POLL_CONFIG;
            end
            POLL_CONFIG: begin
                timed = 1'b1;
                if (done) state_d = CONFIG;
            end
            CONFIG: begin
                timed = 1'b1;
                if (done) state_d = CONFIG_IDLE;
            end
            CONFIG_IDLE: begin
                timed = 1'b1;
                if (done) state_d = L0;
            end
            L0: begin
                if (link_disable_i)                                   state_d = DISABLED;
                else if (loopback_req_i)                              state_d = LOOPBACK;
                else if (retrain_i || |(rx_eios_i & active_lanes_q))  state_d = RECOVERY;
            end
            RECOVERY: begin
                timed = 1'b1;
                if (done) state_d = CONFIG_IDLE;
            end
            DISABLED: begin
                if (!link_disable_i) state_d = DETECT_QUIET;
            end
            LOOPBACK: begin
                if (!loopback_req_i) state_d = DETECT_QUIET;
            end
            default: state_d = DETECT_QUIET;
        endcase

        if (timed && !done && (timer_q == TMO_LAST)) begin
            state_d   = DETECT_QUIET;
            timeout_d = 1'b1;
        end
    end

    // State, counters and registered outputs; every counter clears on state entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= DETECT_QUIET;
            timer_q        <= '0;
            tx_cnt_q       <= '0;
            rx_cnt_q       <= '0;
            active_lanes_q <= '0;
            tx_valid_q     <= 1'b0;
            tx_type_q      <= TX_NONE;
            detect_en_q    <= 1'b0;
            link_up_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
            if (latch_d) active_lanes_q <= rx_detected_i;

            if (state_d != state_q) begin
                timer_q  <= '0;
                tx_cnt_q <= '0;
                rx_cnt_q <= '0;
            end else begin
                if (timer_q != TMR_MAX) timer_q <= timer_q + 1'b1;
                if (tx_valid_q && tx_ready_i && (tx_cnt_q != TX_MIN)) tx_cnt_q <= tx_cnt_q + 1'b1;
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (rx_hit[l] && (rx_cnt_q[l] != RX_REQ)) rx_cnt_q[l] <= rx_cnt_q[l] + 1'b1;
                end
            end

            detect_en_q <= (state_d == DETECT_ACTIVE);
            link_up_q   <= (state_d == L0);
            case (state_d)
                POLL_ACTIVE, RECOVERY: begin tx_valid_q <= 1'b1; tx_type_q <= TX_TS1; end
                POLL_CONFIG, CONFIG:   begin tx_valid_q <= 1'b1; tx_type_q <= TX_TS2; end
                CONFIG_IDLE:           begin tx_valid_q <= 1'b1; tx_type_q <= TX_IDL; end
                default:               begin tx_valid_q <= 1'b0; tx_type_q <= TX_NONE; end
            endcase
        end
    end

    assign tx_valid_o     = tx_valid_q;
    assign tx_type_o      = tx_type_q;
    assign detect_en_o    = detect_en_q;
    assign active_lanes_o = active_lanes_q;
    assign link_up_o      = link_up_q;
    assign timeout_o      = timeout_q;
    assign ltssm_state_o  = state_q;

endmodule

// File: tb/tb_pcie_ltssm_ctrl.sv
// Directed bench for pcie_ltssm_ctrl: bring-up, partial width, no receiver, timeout, tie, L0 exits, reset.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// tx_ready_i held high except in the back-pressure tie case.
module tb_pcie_ltssm_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] rx_detected_i, rx_ts1_i, rx_ts2_i, rx_idl_i, rx_eios_i;
    logic       retrain_i, link_disable_i, loopback_req_i;
    logic       tx_valid_o;
    logic [1:0] tx_type_o;
    logic       tx_ready_i;
    logic       detect_en_o;
    logic [3:0] active_lanes_o;
    logic       link_up_o, timeout_o;
    logic [3:0] ltssm_state_o;

    int tests_run = 0;
    int tests_failed = 0;

    pcie_ltssm_ctrl #(
        .NUM_LANES(4), .TIMEOUT_CYCLES(64), .DETECT_CYCLES(8), .TS_TX_MIN(16), .TS_RX_REQ(8)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rx_detected_i(rx_detected_i), .rx_ts1_i(rx_ts1_i), .rx_ts2_i(rx_ts2_i),
        .rx_idl_i(rx_idl_i), .rx_eios_i(rx_eios_i),
        .retrain_i(retrain_i), .link_disable_i(link_disable_i), .loopback_req_i(loopback_req_i),
        .tx_valid_o(tx_valid_o), .tx_type_o(tx_type_o), .tx_ready_i(tx_ready_i),
        .detect_en_o(detect_en_o), .active_lanes_o(active_lanes_o),
        .link_up_o(link_up_o), .timeout_o(timeout_o), .ltssm_state_o(ltssm_state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_rx();
        rx_ts1_i = '0; rx_ts2_i = '0; rx_idl_i = '0; rx_eios_i = '0;
    endtask

    // Step until POLL_ACTIVE is reached, bounded.
    task automatic go_detect();
        for (int i = 0; i < 40; i++) begin
            if (ltssm_state_o == 4'd2) break;
            step();
        end
        chk("reach_poll_active", {28'd0, ltssm_state_o}, 32'd2);
    endtask

    // Peer sends 8 sets of 'kind' on 'mask' lanes, tx_ready=1: exit lands on the 17th edge.
    task automatic run_state(input logic [3:0] cur, input logic [3:0] nxt,
                             input int kind, input logic [3:0] mask, input logic [1:0] ttype);
        tx_ready_i = 1'b1;
        for (int t = 0; t <= 16; t++) begin
            clear_rx();
            if (t < 8) begin
                if (kind == 0) rx_ts1_i = mask;
                else if (kind == 1) rx_ts2_i = mask;
                else rx_idl_i = mask;
            end
            step();
            if (t == 15) begin
                chk("hold_state", {28'd0, ltssm_state_o}, {28'd0, cur});
                chk("tx_valid_in_state", {31'd0, tx_valid_o}, 32'd1);
                chk("tx_type_in_state", {30'd0, tx_type_o}, {30'd0, ttype});
            end
        end
        clear_rx();
        chk("exit_state", {28'd0, ltssm_state_o}, {28'd0, nxt});
    endtask

    initial begin
        rst_ni = 1'b0;
        rx_detected_i = '0; clear_rx();
        retrain_i = 1'b0; link_disable_i = 1'b0; loopback_req_i = 1'b0; tx_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_state", {28'd0, ltssm_state_o}, 32'd0);
        chk("rst_outs", {22'd0, tx_valid_o, tx_type_o, detect_en_o, active_lanes_o, link_up_o, timeout_o}, 32'd0);
        rst_ni = 1'b1;

        // No receiver: 0 for 8 cycles, 1 for 8 cycles, back to 0; never transmits.
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("norx_state", {28'd0, ltssm_state_o}, (i >= 8 && i < 16) ? 32'd1 : 32'd0);
            chk("norx_detect_en", {31'd0, detect_en_o}, (i >= 8 && i < 16) ? 32'd1 : 32'd0);
            chk("norx_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        end
        chk("norx_active", {28'd0, active_lanes_o}, 32'd0);

        // Full bring-up on all four lanes.
        rx_detected_i = 4'b1111;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("det_state", {28'd0, ltssm_state_o}, (i < 8) ? 32'd0 : ((i < 16) ? 32'd1 : 32'd2));
        end
        chk("full_active", {28'd0, active_lanes_o}, 32'hF);
        run_state(4'd2, 4'd3, 0, 4'b1111, 2'd1);
        run_state(4'd3, 4'd4, 1, 4'b1111, 2'd2);
        run_state(4'd4, 4'd5, 1, 4'b1111, 2'd2);
        run_state(4'd5, 4'd6, 2, 4'b1111, 2'd3);
        chk("l0_link_up", {31'd0, link_up_o}, 32'd1);
        chk("l0_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        chk("l0_tx_type", {30'd0, tx_type_o}, 32'd0);

        // Disable beats loopback; Disabled held until disable drops.
        link_disable_i = 1'b1; loopback_req_i = 1'b1;
        step();
        chk("l0_to_disabled", {28'd0, ltssm_state_o}, 32'd8);
        chk("disabled_link_up", {31'd0, link_up_o}, 32'd0);
        step();
        chk("disabled_hold", {28'd0, ltssm_state_o}, 32'd8);
        link_disable_i = 1'b0;
        step();
        chk("disabled_exit", {28'd0, ltssm_state_o}, 32'd0);
        loopback_req_i = 1'b0;

        // Partial width: lanes 0-1 only; lanes 2-3 silent.
        rx_detected_i = 4'b0011;
        go_detect();
        chk("part_active", {28'd0, active_lanes_o}, 32'h3);
        run_state(4'd2, 4'd3, 0, 4'b0011, 2'd1);
        run_state(4'd3, 4'd4, 1, 4'b0011, 2'd2);
        run_state(4'd4, 4'd5, 1, 4'b0011, 2'd2);
        run_state(4'd5, 4'd6, 2, 4'b0011, 2'd3);
        rx_eios_i = 4'b0100;
        step();
        chk("eios_inactive_ignored", {28'd0, ltssm_state_o}, 32'd6);
        rx_eios_i = 4'b0001;
        step();
        rx_eios_i = 4'b0000;
        chk("eios_active_recovery", {28'd0, ltssm_state_o}, 32'd7);
        run_state(4'd7, 4'd5, 0, 4'b0011, 2'd1);
        run_state(4'd5, 4'd6, 2, 4'b0011, 2'd3);
        loopback_req_i = 1'b1;
        step();
        chk("l0_to_loopback", {28'd0, ltssm_state_o}, 32'd9);
        loopback_req_i = 1'b0;
        step();
        chk("loopback_exit", {28'd0, ltssm_state_o}, 32'd0);

        // Timeout: lane 3 sends only 7 TS1.
        rx_detected_i = 4'b1111;
        go_detect();
        tx_ready_i = 1'b1;
        for (int t = 0; t <= 63; t++) begin
            clear_rx();
            if (t < 7) rx_ts1_i = 4'b1111;
            else if (t == 7) rx_ts1_i = 4'b0111;
            step();
            if (t == 62) begin
                chk("tmo_pre_state", {28'd0, ltssm_state_o}, 32'd2);
                chk("tmo_pre_pulse", {31'd0, timeout_o}, 32'd0);
            end
        end
        clear_rx();
        chk("tmo_state", {28'd0, ltssm_state_o}, 32'd0);
        chk("tmo_pulse", {31'd0, timeout_o}, 32'd1);
        step();
        chk("tmo_pulse_once", {31'd0, timeout_o}, 32'd0);

        // Tie: toggling tx_ready, last TS1 lands so done appears at timer==63.
        go_detect();
        for (int t = 0; t <= 63; t++) begin
            clear_rx();
            tx_ready_i = (t % 2 == 0);
            if (t < 7 || t == 62) rx_ts1_i = 4'b1111;
            step();
            chk("tie_no_timeout", {31'd0, timeout_o}, 32'd0);
            if (t == 62) chk("tie_pre_state", {28'd0, ltssm_state_o}, 32'd2);
        end
        clear_rx();
        chk("tie_exit_poll_config", {28'd0, ltssm_state_o}, 32'd3);

        // Reset mid-CONFIG aborts immediately.
        run_state(4'd3, 4'd4, 1, 4'b1111, 2'd2);
        step();
        step();
        rst_ni = 1'b0;
        #1;
        chk("midrst_state", {28'd0, ltssm_state_o}, 32'd0);
        chk("midrst_outs", {22'd0, tx_valid_o, tx_type_o, detect_en_o, active_lanes_o, link_up_o, timeout_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
